// File: rtl/ps2_key_event_if.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_event_if
// Purpose  : Key-event stream (valid/ready) between the PS/2 front end and its
//            consumers.
// Revision : 1.0
// ============================================================================
interface ps2_key_event_if;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;
    logic [3:0] ev_mods;

    modport master (output ev_valid, ev_code, ev_ext, ev_break, ev_mods,
                    input  ev_ready);
    modport slave  (input  ev_valid, ev_code, ev_ext, ev_break, ev_mods,
                    output ev_ready);
endinterface
`default_nettype wire

// File: rtl/ps2_key_event.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_event
// Purpose  : PS/2 keyboard receiver, make/break decoder, modifier tracking,
//            press counter and event FIFO. Optional: KEY_REPEAT_FILTER_EN.
// Revision : 1.0
// ============================================================================
module ps2_key_event #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 8,
    parameter int TIMEOUT    = 50000
) (
    input  wire              clk,
    input  wire              clrn,
    input  wire              ps2_clk,
    input  wire              ps2_data,
    ps2_key_event_if.master  ev,
    output logic [CNT_W-1:0] press_cnt,
    output logic             overflow,
    output logic             frame_err
);
    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_PW = c_AW + 1;
    localparam int c_TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXT     = 2'd1,
        S_BRK     = 2'd2,
        S_EXT_BRK = 2'd3
    } state_t;

    logic [1:0]      r_clk_sync, r_dat_sync;
    logic            r_clk_prev;
    logic [10:0]     r_shift;
    logic [3:0]      r_bitcnt;
    logic [c_TW-1:0] r_idle;
    logic            r_byte_vld;
    logic [7:0]      r_byte;
    logic            w_fall, w_good;
    logic [10:0]     w_frame;

    // Synchronisers idle high so reset release cannot fake a falling edge
    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[0], ps2_clk};
            r_dat_sync <= {r_dat_sync[0], ps2_data};
            r_clk_prev <= r_clk_sync[1];
        end
    end

    assign w_fall  = r_clk_prev & ~r_clk_sync[1];
    assign w_frame = {r_dat_sync[1], r_shift[10:1]};
    assign w_good  = ~w_frame[0] & w_frame[10] & (^w_frame[9:1]);

    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_shift    <= '0;
            r_bitcnt   <= '0;
            r_idle     <= '0;
            r_byte_vld <= 1'b0;
            r_byte     <= '0;
            frame_err  <= 1'b0;
        end else begin
            r_byte_vld <= 1'b0;
            frame_err  <= 1'b0;
            if (w_fall) begin
                r_idle  <= '0;
                r_shift <= w_frame;
                if (r_bitcnt == 4'd10) begin
                    r_bitcnt <= '0;
                    if (w_good) begin
                        r_byte_vld <= 1'b1;
                        r_byte     <= w_frame[8:1];
                    end else begin
                        frame_err <= 1'b1;
                    end
                end else begin
                    r_bitcnt <= r_bitcnt + 4'd1;
                end
            end else if (r_bitcnt != 4'd0) begin
                if (r_idle == c_TW'(TIMEOUT - 1)) begin
                    r_bitcnt  <= '0;
                    r_idle    <= '0;
                    frame_err <= 1'b1;
                end else begin
                    r_idle <= r_idle + c_TW'(1);
                end
            end else begin
                r_idle <= '0;
            end
        end
    end

    state_t r_state, w_state_nxt;
    logic   w_emit, w_ev_ext, w_ev_brk, w_ignore;

    assign w_ignore = (r_byte == 8'hFA) || (r_byte == 8'hAA) || (r_byte == 8'hEE) ||
                      (r_byte == 8'hFE) || (r_byte == 8'h00) || (r_byte == 8'hFF);

    always_ff @(posedge clk) begin
        if (!clrn) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_emit      = 1'b0;
        w_ev_ext    = 1'b0;
        w_ev_brk    = 1'b0;
        if (r_byte_vld) begin
            case (r_state)
                S_IDLE: begin
                    if (r_byte == 8'hE0)      w_state_nxt = S_EXT;
                    else if (r_byte == 8'hF0) w_state_nxt = S_BRK;
                    else if (!w_ignore)       w_emit = 1'b1;
                end
                S_EXT: begin
                    if (r_byte == 8'hF0) begin
                        w_state_nxt = S_EXT_BRK;
                    end else if (r_byte != 8'hE0) begin
                        w_emit      = 1'b1;
                        w_ev_ext    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                S_BRK: begin
                    w_emit      = 1'b1;
                    w_ev_brk    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_emit      = 1'b1;
                    w_ev_ext    = 1'b1;
                    w_ev_brk    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    logic [8:0] w_key;
    logic       w_repeat, w_fire;
    assign w_key = {w_ev_ext, r_byte};

`ifdef KEY_REPEAT_FILTER_EN
    logic [8:0] r_last;
    assign w_repeat = w_emit & ~w_ev_brk & (w_key == r_last);
    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_last <= '0;
        end else if (w_emit && !w_repeat) begin
            if (!w_ev_brk)            r_last <= w_key;
            else if (w_key == r_last) r_last <= '0;
        end
    end
`else
    assign w_repeat = 1'b0;
`endif

    assign w_fire = w_emit & ~w_repeat;

    // Held bits: 0 lshift, 1 rshift, 2 lctrl, 3 rctrl, 4 lalt, 5 ralt, 6 caps key
    logic [6:0] r_held, w_held_nxt;
    logic       r_caps, w_caps_nxt;
    logic [3:0] w_mods_nxt;

    always_comb begin
        w_held_nxt = r_held;
        w_caps_nxt = r_caps;
        if (w_fire) begin
            case (w_key)
                9'h012: w_held_nxt[0] = ~w_ev_brk;
                9'h059: w_held_nxt[1] = ~w_ev_brk;
                9'h014: w_held_nxt[2] = ~w_ev_brk;
                9'h114: w_held_nxt[3] = ~w_ev_brk;
                9'h011: w_held_nxt[4] = ~w_ev_brk;
                9'h111: w_held_nxt[5] = ~w_ev_brk;
                9'h058: begin
                    if (!w_ev_brk && !r_held[6]) w_caps_nxt = ~r_caps;
                    w_held_nxt[6] = ~w_ev_brk;
                end
                default: ;
            endcase
        end
        w_mods_nxt = {w_caps_nxt, w_held_nxt[4] | w_held_nxt[5],
                      w_held_nxt[2] | w_held_nxt[3], w_held_nxt[0] | w_held_nxt[1]};
    end

    logic [13:0]     r_mem [FIFO_DEPTH];
    logic [c_PW-1:0] r_wr, r_rd;
    logic            w_empty, w_full, w_pop, w_push;
    logic [13:0]     w_head;

    assign w_empty = (r_wr == r_rd);
    assign w_full  = (r_wr[c_AW] != r_rd[c_AW]) && (r_wr[c_AW-1:0] == r_rd[c_AW-1:0]);
    assign w_pop   = ~w_empty & ev.ev_ready;
    assign w_push  = w_fire & (~w_full | w_pop);
    assign w_head  = w_empty ? 14'd0 : r_mem[r_rd[c_AW-1:0]];

    assign ev.ev_valid = ~w_empty;
    assign ev.ev_code  = w_head[13:6];
    assign ev.ev_ext   = w_head[5];
    assign ev.ev_break = w_head[4];
    assign ev.ev_mods  = w_head[3:0];

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr[c_AW-1:0]] <= {r_byte, w_ev_ext, w_ev_brk, w_mods_nxt};
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_wr      <= '0;
            r_rd      <= '0;
            overflow  <= 1'b0;
            r_held    <= '0;
            r_caps    <= 1'b0;
            press_cnt <= '0;
        end else begin
            r_held <= w_held_nxt;
            r_caps <= w_caps_nxt;
            if (w_push) r_wr <= r_wr + c_PW'(1);
            if (w_pop)  r_rd <= r_rd + c_PW'(1);
            if (w_fire && w_full && !w_pop) overflow <= 1'b1;
            if (w_fire && !w_ev_brk) press_cnt <= press_cnt + CNT_W'(1);
        end
    end
endmodule
`default_nettype wire
